imem_loader: RTL

Boot-time program loader that fills the DLX pipeline's instruction memory from a byte-serial stream and holds the CPU in reset until the image is complete and verified. It is the writer side of the instruction-memory interface that the CPU fetch stage reads. It replaces file-based preloading when the design runs outside simulation. It sits between the host byte link and the imem write port, and drives the CPU's reset.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader
//                (FSM state encoding, frame field sizes, DLX text base).
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_ADDR  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Frame field sizes in bytes
  localparam int ADDR_BYTES  = 4;
  localparam int COUNT_BYTES = 2;
  localparam int WORD_BYTES  = 4;

  // Start of the DLX text segment; the CPU's PC reset value uses it as well
  localparam logic [31:0] DLX_TEXT_BASE = 32'h0040_0000;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Big-endian 4-byte shift register. Presents the assembled
//                word combinationally together with the byte that completes
//                it, so the caller can register it on the same edge.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  idx,
  output logic [31:0] word,
  output logic        word_valid
);

  // Only the three earlier bytes need storage; the fourth is the live input
  logic [23:0] r_shift;
  logic [1:0]  r_idx;

  assign word       = {r_shift, byte_in};
  assign word_valid = shift_en && (r_idx == 2'(WORD_BYTES - 1));
  assign idx        = r_idx;

  // Shift one byte in per accepted transfer; index wraps after each word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (clr) begin
      r_idx   <= '0;
    end else if (shift_en) begin
      r_shift <= word[23:0];
      r_idx   <= r_idx + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time loader. Parses a byte-serial frame (base, count,
//                data words, XOR checksum), writes the words into instruction
//                memory and releases the CPU reset once the image verifies.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE = DLX_TEXT_BASE,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  // One past the last legal byte address of the text segment
  localparam logic [33:0] c_limit = {2'b00, TEXT_BASE} + 34'(MAX_WORDS) * 34'd4;

  state_t      r_state;
  logic [7:0]  r_xor;
  logic [31:0] r_base;
  logic [31:0] r_wr_addr;
  logic [15:0] r_count;
  logic [7:0]  r_cnt_hi;
  logic        r_cnt_idx;

  logic        w_take;
  logic        w_pk_shift;
  logic        w_pk_clr;
  logic [1:0]  w_pk_idx;
  logic [31:0] w_pk_word;
  logic        w_pk_valid;
  logic [15:0] w_count;
  logic [33:0] w_end;
  logic        w_hdr_bad;
  logic        w_idle;

  assign w_take     = rx_valid && rx_ready;
  assign w_idle     = (r_state == ST_RUN) || (r_state == ST_ERR);
  assign w_pk_shift = w_take && ((r_state == ST_ADDR) || (r_state == ST_DATA));
  assign w_pk_clr   = w_idle && reload;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (w_pk_clr),
    .shift_en   (w_pk_shift),
    .byte_in    (rx_data),
    .idx        (w_pk_idx),
    .word       (w_pk_word),
    .word_valid (w_pk_valid)
  );

  // Header checks, valid while the second count byte is on rx_data.
  // base + 4N > limit is the same test as base + 4N - 1 > limit - 1 but
  // avoids the underflow when N is zero; 34 bits leave no room to wrap.
  assign w_count   = {r_cnt_hi, rx_data};
  assign w_end     = {2'b00, r_base} + {16'h0000, w_count, 2'b00};
  assign w_hdr_bad = (r_base[1:0] != 2'b00)
                  || (r_base < TEXT_BASE)
                  || ({16'h0000, w_count} > 32'(MAX_WORDS))
                  || (w_end > c_limit);

  // Frame FSM with registered handshake, write port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ADDR;
      r_xor        <= '0;
      r_base       <= '0;
      r_wr_addr    <= '0;
      r_count      <= '0;
      r_cnt_hi     <= '0;
      r_cnt_idx    <= 1'b0;
      rx_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst_n    <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        ST_ADDR: begin
          if (w_take) begin
            r_xor <= r_xor ^ rx_data;
            if (w_pk_idx == 2'(ADDR_BYTES - 1)) begin
              r_base  <= w_pk_word;
              r_state <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (w_take) begin
            r_xor <= r_xor ^ rx_data;
            if (r_cnt_idx == 1'(COUNT_BYTES - 1)) begin
              r_cnt_idx <= 1'b0;
              r_count   <= w_count;
              r_wr_addr <= r_base;
              if (w_hdr_bad) begin
                r_state    <= ST_ERR;
                rx_ready   <= 1'b0;
                load_error <= 1'b1;
              end else if (w_count == 16'd0) begin
                r_state <= ST_CSUM;
              end else begin
                r_state <= ST_DATA;
              end
            end else begin
              r_cnt_hi  <= rx_data;
              r_cnt_idx <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_take) begin
            r_xor <= r_xor ^ rx_data;
            if (w_pk_valid) begin
              imem_we      <= 1'b1;
              imem_addr    <= r_wr_addr;
              imem_wdata   <= w_pk_word;
              r_wr_addr    <= r_wr_addr + 32'(WORD_BYTES);
              words_loaded <= words_loaded + 16'd1;
              if (words_loaded + 16'd1 == r_count) begin
                r_state <= ST_CSUM;
              end
            end
          end
        end
        ST_CSUM: begin
          if (w_take) begin
            rx_ready <= 1'b0;
            if (rx_data == r_xor) begin
              r_state   <= ST_RUN;
              cpu_rst_n <= 1'b1;
              load_done <= 1'b1;
            end else begin
              r_state    <= ST_ERR;
              load_error <= 1'b1;
            end
          end
        end
        ST_RUN, ST_ERR: begin
          if (reload) begin
            r_state      <= ST_ADDR;
            rx_ready     <= 1'b1;
            cpu_rst_n    <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            r_xor        <= '0;
            r_cnt_idx    <= 1'b0;
            words_loaded <= '0;
          end
        end
        default: begin
          r_state  <= ST_ADDR;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
